// File: rtl/ranging_pkg.sv
// Shared types and constants for the ultrasonic ranging sequencer.
package ranging_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } ranging_state_t;

  localparam logic [15:0] CM_SAT = 16'hFFFF;

  // Defaults assume a 100 MHz ACLK: 10 us trigger, 58 us per centimetre.
  localparam int unsigned TRIG_CYCLES_DEF = 1000;
  localparam int unsigned CM_CYCLES_DEF   = 5800;

endpackage

// File: rtl/ultrasonic_ranging_ctrl_if.sv
// Register-block side of the ranging sequencer: control/config in, results and status out.
interface ultrasonic_ranging_ctrl_if #(
  parameter int unsigned CNT_W = 24
);
  logic             start;
  logic             cfg_enable;
  logic             cfg_continuous;
  logic [CNT_W-1:0] cfg_timeout;
  logic [CNT_W-1:0] cfg_holdoff;
  logic             busy;
  logic             result_valid;
  logic [CNT_W-1:0] result_cycles;
  logic [15:0]      result_cm;
  logic             result_timeout;
  logic             done_pulse;
  logic [2:0]       state_o;

  modport master (
    output start, cfg_enable, cfg_continuous, cfg_timeout, cfg_holdoff,
    input  busy, result_valid, result_cycles, result_cm, result_timeout,
           done_pulse, state_o
  );

  modport slave (
    input  start, cfg_enable, cfg_continuous, cfg_timeout, cfg_holdoff,
    output busy, result_valid, result_cycles, result_cm, result_timeout,
           done_pulse, state_o
  );
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with registered rise/fall strobes.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/ultrasonic_ranging_ctrl.sv
// Ultrasonic ranging sequencer: trigger pulse, echo timing, cm conversion, timeout and hold-off.
module ultrasonic_ranging_ctrl
  import ranging_pkg::*;
#(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned TRIG_CYCLES = TRIG_CYCLES_DEF,
  parameter int unsigned CM_CYCLES   = CM_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic                           echo_in,
  output logic                           trig_out,
  ultrasonic_ranging_ctrl_if.slave       bus
);

  localparam int unsigned      SUB_W     = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CM_CYCLES - 1);

  ranging_state_t   state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d, tmr_inc, hold_last;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [15:0]      cm_q, cm_d;
  logic [CNT_W-1:0] res_cyc_q, res_cyc_d;
  logic [15:0]      res_cm_q, res_cm_d;
  logic             res_to_q, res_to_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             trig_q, busy_q;
  logic             echo_rise, echo_fall, timeout_hit;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_echo_sync (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .async_in (echo_in),
    .rise     (echo_rise),
    .fall     (echo_fall)
  );

  // Shared timer: trigger width in TRIG, timeout in WAIT_RISE/MEASURE, gap in HOLDOFF.
  assign tmr_inc     = (tmr_q == '1) ? tmr_q : tmr_q + CNT_W'(1);
  assign hold_last   = (bus.cfg_holdoff == '0) ? '0 : bus.cfg_holdoff - CNT_W'(1);
  assign timeout_hit = (bus.cfg_timeout != '0) && (tmr_inc == bus.cfg_timeout);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cyc_d     = cyc_q;
    sub_d     = sub_q;
    cm_d      = cm_q;
    res_cyc_d = res_cyc_q;
    res_cm_d  = res_cm_q;
    res_to_d  = res_to_q;
    valid_d   = valid_q;
    done_d    = 1'b0;

    if (!bus.cfg_enable && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cfg_enable && (bus.start || bus.cfg_continuous)) begin
            state_d = ST_TRIG;
            tmr_d   = '0;
          end
        end
        ST_TRIG: begin
          if (tmr_q == TRIG_LAST) begin
            state_d = ST_WAIT_RISE;
            tmr_d   = '0;
            cyc_d   = '0;
            sub_d   = '0;
            cm_d    = '0;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        ST_WAIT_RISE: begin
          tmr_d = tmr_inc;
          if (timeout_hit) begin
            state_d   = ST_HOLDOFF;
            tmr_d     = '0;
            res_cyc_d = cyc_q;
            res_cm_d  = CM_SAT;
            res_to_d  = 1'b1;
            valid_d   = 1'b1;
            done_d    = 1'b1;
          end else if (echo_rise) begin
            state_d = ST_MEASURE;
            cyc_d   = '0;
            sub_d   = '0;
            cm_d    = '0;
          end
        end
        ST_MEASURE: begin
          tmr_d = tmr_inc;
          cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            cm_d  = (cm_q == CM_SAT) ? cm_q : cm_q + 16'd1;
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
          // A falling edge coinciding with the timeout still yields a real measurement.
          if (echo_fall) begin
            state_d   = ST_HOLDOFF;
            tmr_d     = '0;
            res_cyc_d = cyc_d;
            res_cm_d  = cm_d;
            res_to_d  = 1'b0;
            valid_d   = 1'b1;
            done_d    = 1'b1;
          end else if (timeout_hit) begin
            state_d   = ST_HOLDOFF;
            tmr_d     = '0;
            res_cyc_d = cyc_d;
            res_cm_d  = CM_SAT;
            res_to_d  = 1'b1;
            valid_d   = 1'b1;
            done_d    = 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (tmr_q >= hold_last) begin
            state_d = (bus.cfg_enable && bus.cfg_continuous) ? ST_TRIG : ST_IDLE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      cyc_q     <= '0;
      sub_q     <= '0;
      cm_q      <= '0;
      res_cyc_q <= '0;
      res_cm_q  <= '0;
      res_to_q  <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cyc_q     <= cyc_d;
      sub_q     <= sub_d;
      cm_q      <= cm_d;
      res_cyc_q <= res_cyc_d;
      res_cm_q  <= res_cm_d;
      res_to_q  <= res_to_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      trig_q    <= (state_d == ST_TRIG);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign trig_out           = trig_q;
  assign bus.busy           = busy_q;
  assign bus.result_valid   = valid_q;
  assign bus.result_cycles  = res_cyc_q;
  assign bus.result_cm      = res_cm_q;
  assign bus.result_timeout = res_to_q;
  assign bus.done_pulse     = done_q;
  assign bus.state_o        = state_q;

endmodule

// File: tb/tb_ultrasonic_ranging_ctrl.sv
// Directed bench for ultrasonic_ranging_ctrl: 24-bit instance for main flows, 8-bit for saturation.
module tb_ultrasonic_ranging_ctrl;

  localparam int unsigned TRIG = 10;
  localparam int unsigned CM   = 58;

  logic clk = 1'b0;
  logic rst_n;
  logic echo;
  logic trig24, trig8;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   dones;

  always #5 clk = ~clk;

  ultrasonic_ranging_ctrl_if #(.CNT_W(24)) bus24 ();
  ultrasonic_ranging_ctrl_if #(.CNT_W(8))  bus8 ();

  ultrasonic_ranging_ctrl #(.CNT_W(24), .TRIG_CYCLES(TRIG), .CM_CYCLES(CM), .SYNC_STAGES(2)) dut24 (
    .ACLK(clk), .ARESETN(rst_n), .echo_in(echo), .trig_out(trig24), .bus(bus24)
  );

  ultrasonic_ranging_ctrl #(.CNT_W(8), .TRIG_CYCLES(TRIG), .CM_CYCLES(CM), .SYNC_STAGES(2)) dut8 (
    .ACLK(clk), .ARESETN(rst_n), .echo_in(echo), .trig_out(trig8), .bus(bus8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // sel: 0 = dut24 done_pulse, 1 = dut24 trig_out, 2 = dut8 done_pulse
  task automatic wait_for(input string tag, input int sel, input int limit, output int cnt);
    logic seen;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < limit) begin
      tick(1);
      cnt++;
      case (sel)
        0:       seen = bus24.done_pulse;
        1:       seen = trig24;
        default: seen = bus8.done_pulse;
      endcase
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  // Start pulse, echo first sampled high dly cycles after trig_out falls, held width cycles.
  task automatic run_shot(input int sel, input int dly, input int width, output int cnt);
    if (sel == 2) bus8.start = 1'b1;
    else          bus24.start = 1'b1;
    tick(1);
    bus8.start  = 1'b0;
    bus24.start = 1'b0;
    tick(TRIG);
    tick(dly - 1);
    echo = 1'b1;
    tick(width);
    echo = 1'b0;
    wait_for("shot_done", (sel == 2) ? 2 : 0, 400, cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    echo  = 1'b0;
    bus24.start = 1'b0; bus24.cfg_enable = 1'b1; bus24.cfg_continuous = 1'b0;
    bus24.cfg_timeout = '0; bus24.cfg_holdoff = 24'd5;
    bus8.start = 1'b0; bus8.cfg_enable = 1'b1; bus8.cfg_continuous = 1'b0;
    bus8.cfg_timeout = '0; bus8.cfg_holdoff = 8'd1;
    tick(3);
    check_eq("rst_state", 32'(bus24.state_o), 32'd0);
    check_eq("rst_trig", 32'(trig24), 32'd0);
    check_eq("rst_busy", 32'(bus24.busy), 32'd0);
    check_eq("rst_valid", 32'(bus24.result_valid), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // One-shot, 580-cycle echo
    bus24.start = 1'b1;
    tick(1);
    bus24.start = 1'b0;
    check_eq("t1_trig_on", 32'(trig24), 32'd1);
    check_eq("t1_state_trig", 32'(bus24.state_o), 32'd1);
    check_eq("t1_busy", 32'(bus24.busy), 32'd1);
    tick(TRIG - 1);
    check_eq("t1_trig_last", 32'(trig24), 32'd1);
    tick(1);
    check_eq("t1_trig_off", 32'(trig24), 32'd0);
    check_eq("t1_state_wait", 32'(bus24.state_o), 32'd2);
    tick(49);
    echo = 1'b1;
    tick(580);
    echo = 1'b0;
    wait_for("t1_done", 0, 20, n);
    check_eq("t1_done_lat", 32'(n), 32'd4);
    check_eq("t1_cycles", 32'(bus24.result_cycles), 32'd580);
    check_eq("t1_cm", 32'(bus24.result_cm), 32'd10);
    check_eq("t1_to", 32'(bus24.result_timeout), 32'd0);
    check_eq("t1_valid", 32'(bus24.result_valid), 32'd1);
    check_eq("t1_state_hold", 32'(bus24.state_o), 32'd4);
    tick(1);
    check_eq("t1_done_single", 32'(bus24.done_pulse), 32'd0);
    tick(3);
    check_eq("t1_hold_end", 32'(bus24.state_o), 32'd4);
    tick(1);
    check_eq("t1_idle", 32'(bus24.state_o), 32'd0);

    // Timeout with echo low, then with echo stuck high
    bus24.cfg_timeout = 24'd200;
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        echo = 1'b1;
        tick(10);
      end
      bus24.start = 1'b1;
      tick(1);
      bus24.start = 1'b0;
      tick(TRIG);
      check_eq("t2_state_wait", 32'(bus24.state_o), 32'd2);
      wait_for("t2_done", 0, 400, n);
      check_eq("t2_done_lat", 32'(n), 32'd200);
      check_eq("t2_cm", 32'(bus24.result_cm), 32'hFFFF);
      check_eq("t2_to", 32'(bus24.result_timeout), 32'd1);
      check_eq("t2_cycles", 32'(bus24.result_cycles), 32'd0);
      echo = 1'b0;
      tick(5);
      check_eq("t2_idle", 32'(bus24.state_o), 32'd0);
    end

    // Fall exactly at the timeout count wins; one cycle later the timeout wins
    bus24.cfg_timeout = 24'd300;
    run_shot(0, 50, 247, n);
    check_eq("t6_lat", 32'(n), 32'd4);
    check_eq("t6_cycles", 32'(bus24.result_cycles), 32'd247);
    check_eq("t6_cm", 32'(bus24.result_cm), 32'd4);
    check_eq("t6_to", 32'(bus24.result_timeout), 32'd0);
    tick(6);
    run_shot(0, 50, 248, n);
    check_eq("t6b_lat", 32'(n), 32'd3);
    check_eq("t6b_cycles", 32'(bus24.result_cycles), 32'd247);
    check_eq("t6b_cm", 32'(bus24.result_cm), 32'hFFFF);
    check_eq("t6b_to", 32'(bus24.result_timeout), 32'd1);
    tick(6);
    check_eq("t6b_idle", 32'(bus24.state_o), 32'd0);

    // Continuous mode, 116-cycle echo, 50-cycle hold-off, start held during hold-off
    bus24.cfg_timeout = '0;
    bus24.cfg_holdoff = 24'd50;
    bus24.cfg_continuous = 1'b1;
    wait_for("t3_first_trig", 1, 5, n);
    check_eq("t3_first_lat", 32'(n), 32'd1);
    for (int m = 0; m < 2; m++) begin
      tick(TRIG);
      check_eq("t3_state_wait", 32'(bus24.state_o), 32'd2);
      tick(4);
      echo = 1'b1;
      tick(116);
      echo = 1'b0;
      wait_for("t3_done", 0, 20, n);
      check_eq("t3_cm", 32'(bus24.result_cm), 32'd2);
      check_eq("t3_cycles", 32'(bus24.result_cycles), 32'd116);
      check_eq("t3_to", 32'(bus24.result_timeout), 32'd0);
      if (m == 0) begin
        bus24.start = 1'b1;
        wait_for("t3_gap_trig", 1, 80, n);
        bus24.start = 1'b0;
        check_eq("t3_gap", 32'(n), 32'd50);
      end else begin
        bus24.cfg_continuous = 1'b0;
        tick(49);
        check_eq("t3_last_hold", 32'(bus24.state_o), 32'd4);
        tick(1);
        check_eq("t3_stop_idle", 32'(bus24.state_o), 32'd0);
      end
    end

    // Abort during MEASURE
    bus24.cfg_holdoff = 24'd5;
    bus24.start = 1'b1;
    tick(1);
    bus24.start = 1'b0;
    tick(TRIG + 4);
    echo = 1'b1;
    tick(20);
    check_eq("t5_state_meas", 32'(bus24.state_o), 32'd3);
    bus24.cfg_enable = 1'b0;
    tick(1);
    check_eq("t5_abort_state", 32'(bus24.state_o), 32'd0);
    check_eq("t5_abort_trig", 32'(trig24), 32'd0);
    check_eq("t5_abort_busy", 32'(bus24.busy), 32'd0);
    echo = 1'b0;
    bus24.cfg_enable = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      dones += int'(bus24.done_pulse);
      tick(1);
    end
    check_eq("t5_no_done", 32'(dones), 32'd0);
    check_eq("t5_keep_cycles", 32'(bus24.result_cycles), 32'd116);
    check_eq("t5_keep_cm", 32'(bus24.result_cm), 32'd2);
    check_eq("t5_keep_valid", 32'(bus24.result_valid), 32'd1);
    check_eq("t5_still_idle", 32'(bus24.state_o), 32'd0);

    // Reset in TRIG
    bus24.start = 1'b1;
    tick(1);
    bus24.start = 1'b0;
    check_eq("t5_in_trig", 32'(bus24.state_o), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check_eq("t5_rst_trig", 32'(trig24), 32'd0);
    check_eq("t5_rst_busy", 32'(bus24.busy), 32'd0);
    check_eq("t5_rst_valid", 32'(bus24.result_valid), 32'd0);
    check_eq("t5_rst_cycles", 32'(bus24.result_cycles), 32'd0);
    check_eq("t5_rst_cm", 32'(bus24.result_cm), 32'd0);
    check_eq("t5_rst_to", 32'(bus24.result_timeout), 32'd0);
    check_eq("t5_rst_done", 32'(bus24.done_pulse), 32'd0);
    check_eq("t5_rst_state", 32'(bus24.state_o), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Saturation and cm boundaries on the 8-bit instance
    run_shot(2, 5, 400, n);
    check_eq("t4_lat", 32'(n), 32'd4);
    check_eq("t4_cycles_sat", 32'(bus8.result_cycles), 32'd255);
    check_eq("t4_cm_400", 32'(bus8.result_cm), 32'd6);
    check_eq("t4_to", 32'(bus8.result_timeout), 32'd0);
    tick(3);
    run_shot(2, 5, 57, n);
    check_eq("t4_cycles_57", 32'(bus8.result_cycles), 32'd57);
    check_eq("t4_cm_57", 32'(bus8.result_cm), 32'd0);
    tick(3);
    run_shot(2, 5, 58, n);
    check_eq("t4_cycles_58", 32'(bus8.result_cycles), 32'd58);
    check_eq("t4_cm_58", 32'(bus8.result_cm), 32'd1);
    check_eq("t4_valid", 32'(bus8.result_valid), 32'd1);
    tick(3);
    check_eq("t4_idle", 32'(bus8.state_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ultrasonic_ranging_ctrl.md
Name: ultrasonic_ranging_ctrl

Overview:
Sequencer for the distance-sensor datapath behind the AXI4-Lite register file. It issues the ultrasonic trigger pulse, times the echo, converts the echo width to centimetres with a prescaled counter, and reports result and status back to the register block. It runs in one-shot or continuous mode, with a programmable timeout and hold-off.

Parameters:
CNT_W, 24, width of the cycle, timeout and hold-off counters.
TRIG_CYCLES, 1000, trigger pulse width in ACLK cycles (10 us at 100 MHz).
CM_CYCLES, 5800, ACLK cycles per centimetre of echo (58 us at 100 MHz).
SYNC_STAGES, 2, echo synchronizer depth (minimum 2).

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
start  in  1  one-shot request pulse from the register block
cfg_enable  in  1  block enable; deassertion aborts the current measurement
cfg_continuous  in  1  1 = re-trigger automatically after hold-off
cfg_timeout  in  CNT_W  echo timeout in cycles; 0 disables the timeout
cfg_holdoff  in  CNT_W  gap in cycles between measurements in continuous mode
echo_in  in  1  asynchronous sensor echo
trig_out  out  1  sensor trigger
busy  out  1  high in any state except IDLE
result_valid  out  1  sticky; high once the first result is available
result_cycles  out  CNT_W  echo high time in cycles, saturating
result_cm  out  16  distance in centimetres, saturating; 0xFFFF on timeout
result_timeout  out  1  the last result was a timeout
done_pulse  out  1  one-cycle strobe when a result updates
state_o  out  3  current state encoding, for the status register

Behaviour:
- Reset (ARESETN=0 at a rising ACLK edge) sets all outputs to 0 and the state to IDLE. Reset mid-measurement behaves identically and produces no done_pulse.
- echo_in passes through SYNC_STAGES flops. Rise and fall are detected on the synchronized signal against its previous value.
- State encodings: IDLE=0, TRIG=1, WAIT_RISE=2, MEASURE=3, HOLDOFF=4.
- IDLE: go to TRIG when cfg_enable&&start, or when cfg_enable&&cfg_continuous. start is ignored in every other state.
- TRIG: registered trig_out is high exactly while in TRIG. TRIG lasts TRIG_CYCLES cycles, then goes to WAIT_RISE. A start pulse at cycle N drives trig_out high from N+1 through N+TRIG_CYCLES.
- WAIT_RISE: the timeout counter starts at 0 on entry and increments every cycle.
  - A synchronized rising edge goes to MEASURE and clears the cycle and cm counters.
  - An echo already high on entry is not a rise; it must fall and rise again, or the measurement times out.
- MEASURE: the cycle counter increments every cycle the echo is high and saturates at all-ones.
  - A cm sub-counter counts 0..CM_CYCLES-1. On wrap it increments the cm counter, which saturates at 0xFFFF.
  - The timeout counter keeps running.
  - A synchronized falling edge goes to HOLDOFF. On the next cycle result_cycles and result_cm are loaded, result_timeout=0, result_valid=1, done_pulse=1.
- Timeout: cfg_timeout!=0 and the timeout counter reaches cfg_timeout in WAIT_RISE or MEASURE. The block loads result_cycles=current count, result_cm=0xFFFF, result_timeout=1, pulses done_pulse and goes to HOLDOFF.
  - If a timeout and a falling edge occur in the same cycle, the falling edge wins and a normal result is loaded.
- HOLDOFF: lasts max(cfg_holdoff,1) cycles.
  - Then go to TRIG if cfg_enable&&cfg_continuous, otherwise IDLE.
  - The result registers hold their values.
- cfg_enable=0 in any non-IDLE state: go to IDLE on the next cycle and drop trig_out. Results are unchanged and no done_pulse is issued.
- Config inputs are sampled continuously. Software changes them only while busy=0; changes made while busy take effect immediately, and that case is not otherwise guarded.

Decomposition:
- Shared package ranging_pkg holds:
  - the state enum `ranging_state_t` (3 bits, encodings above);
  - constant `CM_SAT=16'hFFFF`;
  - the default TRIG_CYCLES and CM_CYCLES values.
- One sub-module, `sync_edge_det`: a parameterized SYNC_STAGES synchronizer with registered rise/fall outputs. It is reused for other async sensor inputs.

Test Plan (TRIG_CYCLES=10, CM_CYCLES=58, CNT_W=24):
1. One-shot: start pulse at cycle N, echo goes high 50 cycles after trig_out falls and stays high 580 cycles → trig_out high for exactly 10 cycles, result_cycles=580, result_cm=10, result_timeout=0, a single done_pulse, state returns to 0 after max(cfg_holdoff,1) cycles.
2. Timeout: cfg_timeout=200, echo held low → done_pulse 200 cycles after entering WAIT_RISE, result_cm=0xFFFF, result_timeout=1. Repeat with echo stuck high from before TRIG → same timeout result.
3. Continuous: cfg_continuous=1, cfg_holdoff=50, echo 116 cycles per measurement → result_cm=2 each time; each new trig_out rising edge follows the previous done_pulse by exactly 50 cycles. A start pulse issued while busy has no effect.
4. Saturation: CNT_W=8, echo 400 cycles, cfg_timeout=0 → result_cycles=255, result_cm=6 (400/58 truncated). Boundary at echo=57 cycles → result_cm=0; echo=58 cycles → result_cm=1.
5. Abort and reset: deassert cfg_enable in MEASURE → state 0 next cycle, trig_out=0, no done_pulse, results keep their prior values. Assert ARESETN=0 in TRIG → all outputs 0 after one edge, result_valid=0.
6. Simultaneous events: falling edge in the same cycle the timeout count is reached (cfg_timeout=300, echo falls exactly then) → normal result loaded, result_timeout=0.
